bfm_ahbl_burst_master: RTL

//  Parametrised AHB-Lite master engine for BFM testbenches. Takes one command (addr, dir, size, beats)
//  and runs it as a SINGLE or INCR burst, including wait states, BUSY insertion and two-cycle ERROR abort.

---
 rtl/bfm_ahbl_pkg.sv | 24 ++
 rtl/bfm_ahbl_hsel_dec.sv | 19 +
 rtl/bfm_ahbl_burst_master.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bfm_ahbl_pkg.sv
// bfm_ahbl_pkg: AHB-Lite transfer codes, size codes and engine state type
package bfm_ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_DRAIN,
    ST_ERR1,
    ST_ERR2
  } state_t;
  function automatic logic [31:0] size_step(input logic [2:0] size);
    return 32'd1 << size;
  endfunction
endpackage

// File: rtl/bfm_ahbl_hsel_dec.sv
// bfm_ahbl_hsel_dec: one-hot slave select decoded from the top address bits
module bfm_ahbl_hsel_dec #(
  parameter int NUM_SEL = 16
) (
  input  logic [31:0]        addr,
  input  logic               en,
  output logic [NUM_SEL-1:0] sel
);
  localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  logic [SEL_W-1:0] idx;
  logic unused_addr;
  assign idx = (NUM_SEL > 1) ? addr[31 -: SEL_W] : '0;
  assign unused_addr = ^addr;
  // Region index to a single active select; all quiet when no transfer is driven
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SEL; i++) sel[i] = en && (idx == SEL_W'(i));
  end
endmodule

// File: rtl/bfm_ahbl_burst_master.sv
// bfm_ahbl_burst_master: AHB-Lite SINGLE/INCR burst engine; AHBL_1KB_SPLIT_EN restarts bursts at 1 KB boundaries
module bfm_ahbl_burst_master
  import bfm_ahbl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int NUM_SEL    = 16,
  parameter int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [31:0]           CMD_ADDR,
  input  logic                  CMD_WRITE,
  input  logic [2:0]            CMD_SIZE,
  input  logic [LEN_W-1:0]      CMD_LEN,
  input  logic                  WD_VALID,
  output logic                  WD_READY,
  input  logic [DATA_WIDTH-1:0] WD_DATA,
  output logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_LAST,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [NUM_SEL-1:0]    HSEL
);
  state_t st, nst;
  logic                  up;
  logic [31:0]           a_addr;
  logic [2:0]            size;
  logic [LEN_W-1:0]      len, a_cnt;
  logic                  wr, d_act, d_last, done_q;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  aph, have, acc, err;
  logic [1:0]            seq_code;
`ifdef AHBL_1KB_SPLIT_EN
  assign seq_code = (a_addr[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
`else
  assign seq_code = HTRANS_SEQ;
`endif
  // Address-phase outputs; write beats only go out when their data is on hand
  always_comb begin
    aph = (st == ST_ADDR) || (st == ST_BURST);
    have = !wr || WD_VALID;
    HTRANS = (st == ST_ADDR) ? (have ? HTRANS_NONSEQ : HTRANS_IDLE) :
             (st == ST_BURST) ? (have ? seq_code : HTRANS_BUSY) : HTRANS_IDLE;
    acc = HTRANS[1] && HREADY;
    err = d_act && HRESP;
    HADDR = aph ? a_addr : '0;
    HWRITE = aph && wr;
    HSIZE = aph ? size : '0;
    HBURST = aph ? ((len == '0) ? HBURST_SINGLE : HBURST_INCR) : HBURST_SINGLE;
    HWDATA = wdata;
    WD_READY = acc && wr;
    CMD_READY = up && (st == ST_IDLE);
  end
  // Next state: address side walks the beats, error response cancels the rest
  always_comb begin
    nst = st;
    unique case (st)
      ST_IDLE:  nst = (CMD_VALID && CMD_READY) ? ST_ADDR : ST_IDLE;
      ST_ADDR:  nst = acc ? ((len == '0) ? ST_DRAIN : ST_BURST) : ST_ADDR;
      ST_BURST: nst = err ? (HREADY ? ST_ERR2 : ST_ERR1) : (acc && a_cnt == len) ? ST_DRAIN : ST_BURST;
      ST_DRAIN: nst = err ? (HREADY ? ST_ERR2 : ST_ERR1) : HREADY ? ST_IDLE : ST_DRAIN;
      ST_ERR1:  nst = HREADY ? ST_ERR2 : ST_ERR1;
      ST_ERR2:  nst = ST_IDLE;
      default:  nst = ST_IDLE;
    endcase
  end
  // Data-phase and completion outputs; an error response never delivers read data
  always_comb begin
    RD_VALID = d_act && !wr && HREADY && !HRESP;
    RD_DATA = RD_VALID ? HRDATA : '0;
    RD_LAST = RD_VALID && d_last;
    DONE = done_q || (st == ST_ERR2);
    ERROR = (st == ST_ERR2);
  end
  // State register
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) st <= ST_IDLE;
    else st <= nst;
  end
  // Command capture, address/beat advance and data-phase tracking
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      up <= 1'b0;
      a_addr <= '0;
      size <= '0;
      len <= '0;
      a_cnt <= '0;
      wr <= 1'b0;
      d_act <= 1'b0;
      d_last <= 1'b0;
      done_q <= 1'b0;
      wdata <= '0;
    end else begin
      up <= 1'b1;
      done_q <= (st == ST_DRAIN) && (nst == ST_IDLE);
      if (st == ST_IDLE && nst == ST_ADDR) begin
        a_addr <= CMD_ADDR;
        size <= CMD_SIZE;
        len <= CMD_LEN;
        wr <= CMD_WRITE;
        a_cnt <= '0;
      end else if (acc) begin
        a_addr <= a_addr + size_step(size);
        a_cnt <= a_cnt + LEN_W'(1);
      end
      if (WD_READY) wdata <= WD_DATA;
      if (nst != ST_BURST && nst != ST_DRAIN) d_act <= 1'b0;
      else if (HREADY) begin
        d_act <= HTRANS[1];
        d_last <= (a_cnt == len);
      end
    end
  end
  bfm_ahbl_hsel_dec #(.NUM_SEL(NUM_SEL)) u_hsel (
    .addr(HADDR),
    .en  (HTRANS != HTRANS_IDLE),
    .sel (HSEL)
  );
endmodule
